// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core MEM-stage port vs. loader/debug port onto one memory port.
// Define DMEM_ARB_STARVE_EN to let the loader force a grant after STARVE_LIMIT lost conflicts.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_stall,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_rvalid,
  input  logic              l_valid,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ready,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_rvalid,
  output logic              m_en,
  output logic              m_we,
  output logic [31:0]       m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LOAD = 2'd2
  } owner_t;

  logic   c_gnt;
  logic   l_gnt;
  logic   force_l;
  owner_t owner_p0;
  owner_t owner_p1;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
    $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
  end

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign force_l = (starve_cnt == LIMIT);

  // Counts consecutive conflicts the core has won; any loader grant or idle loader restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!l_valid || l_gnt) begin
      starve_cnt <= 4'd0;
    end else if (c_gnt && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_l = 1'b0;
`endif

  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (c_req && l_valid) begin
        l_gnt = force_l;
        c_gnt = !force_l;
      end else begin
        c_gnt = c_req;
        l_gnt = l_valid;
      end
    end
  end

  assign c_stall = c_req && !c_gnt && !rst;
  assign l_ready = l_gnt;

  always_comb begin
    m_en     = c_gnt || l_gnt;
    m_we     = 1'b0;
    m_addr   = 32'd0;
    m_wdata  = '0;
    owner_p0 = OWN_NONE;
    if (c_gnt) begin
      m_we     = c_we;
      m_addr   = c_addr;
      m_wdata  = c_wdata;
      owner_p0 = c_we ? OWN_NONE : OWN_CORE;
    end else if (l_gnt) begin
      m_we     = l_we;
      m_addr   = l_addr;
      m_wdata  = l_wdata;
      owner_p0 = l_we ? OWN_NONE : OWN_LOAD;
    end
  end

  // p0 -> p1: read owner follows the memory's one-cycle read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_p1 <= OWN_NONE;
    end else begin
      owner_p1 <= owner_p0;
    end
  end

  assign c_rvalid = !rst && (owner_p1 == OWN_CORE);
  assign l_rvalid = !rst && (owner_p1 == OWN_LOAD);
  assign c_rdata  = m_rdata;
  assign l_rdata  = m_rdata;

endmodule
